// File: rtl/issue_station.sv
// issue_station: reservation station in front of one execution unit.
// Holds up to DEPTH decoded instructions, captures missing operands from
// the CDB broadcast ports, and issues one operand-complete instruction per
// cycle (lowest slot first) through a valid/ready output register.
module issue_station #(
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 32,
    parameter int ROB_W     = 4,
    parameter int OP_W      = 6,
    parameter int IMM_W     = 32,
    parameter int CDB_PORTS = 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_pc,
    input  logic [OP_W-1:0]               in_op,
    input  logic [ROB_W-1:0]              in_rob,
    input  logic [IMM_W-1:0]              in_imm,
    input  logic                          in_rs1_rdy,
    input  logic [DATA_W-1:0]             in_rs1_val,
    input  logic [ROB_W-1:0]              in_rs1_tag,
    input  logic                          in_rs2_rdy,
    input  logic [DATA_W-1:0]             in_rs2_val,
    input  logic [ROB_W-1:0]              in_rs2_tag,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_W-1:0]    cdb_tag,
    input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OP_W-1:0]               out_op,
    output logic [DATA_W-1:0]             out_pc,
    output logic [DATA_W-1:0]             out_rs1,
    output logic [DATA_W-1:0]             out_rs2,
    output logic [IMM_W-1:0]              out_imm,
    output logic [ROB_W-1:0]              out_rob,
    output logic [CNT_W-1:0]              count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Per-entry state
    logic              busy_q    [DEPTH];
    logic              busy_d    [DEPTH];
    logic [OP_W-1:0]   op_q      [DEPTH];
    logic [OP_W-1:0]   op_d      [DEPTH];
    logic [DATA_W-1:0] pc_q      [DEPTH];
    logic [DATA_W-1:0] pc_d      [DEPTH];
    logic [IMM_W-1:0]  imm_q     [DEPTH];
    logic [IMM_W-1:0]  imm_d     [DEPTH];
    logic [ROB_W-1:0]  rob_q     [DEPTH];
    logic [ROB_W-1:0]  rob_d     [DEPTH];
    logic              rs1_rdy_q [DEPTH];
    logic              rs1_rdy_d [DEPTH];
    logic [DATA_W-1:0] rs1_val_q [DEPTH];
    logic [DATA_W-1:0] rs1_val_d [DEPTH];
    logic [ROB_W-1:0]  rs1_tag_q [DEPTH];
    logic [ROB_W-1:0]  rs1_tag_d [DEPTH];
    logic              rs2_rdy_q [DEPTH];
    logic              rs2_rdy_d [DEPTH];
    logic [DATA_W-1:0] rs2_val_q [DEPTH];
    logic [DATA_W-1:0] rs2_val_d [DEPTH];
    logic [ROB_W-1:0]  rs2_tag_q [DEPTH];
    logic [ROB_W-1:0]  rs2_tag_d [DEPTH];

    // Output register and occupancy
    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   out_op_q,    out_op_d;
    logic [DATA_W-1:0] out_pc_q,    out_pc_d;
    logic [DATA_W-1:0] out_rs1_q,   out_rs1_d;
    logic [DATA_W-1:0] out_rs2_q,   out_rs2_d;
    logic [IMM_W-1:0]  out_imm_q,   out_imm_d;
    logic [ROB_W-1:0]  out_rob_q,   out_rob_d;
    logic [CNT_W-1:0]  count_q,     count_d;

    logic             free_found, elig_found;
    logic [IDX_W-1:0] free_idx,   elig_idx;
    logic             accept, issue;

    // True when any valid CDB port carries the given tag.
    function automatic logic cdb_hit(input logic [ROB_W-1:0]           tag,
                                     input logic [CDB_PORTS-1:0]       vld,
                                     input logic [CDB_PORTS*ROB_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++)
            if (vld[p] && (tags[p*ROB_W +: ROB_W] == tag)) hit = 1'b1;
        return hit;
    endfunction

    // Data from the lowest-numbered valid CDB port carrying the tag.
    function automatic logic [DATA_W-1:0] cdb_pick(input logic [ROB_W-1:0]            tag,
                                                   input logic [CDB_PORTS-1:0]        vld,
                                                   input logic [CDB_PORTS*ROB_W-1:0]  tags,
                                                   input logic [CDB_PORTS*DATA_W-1:0] data);
        logic [DATA_W-1:0] val;
        logic              found;
        val   = '0;
        found = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (!found && vld[p] && (tags[p*ROB_W +: ROB_W] == tag)) begin
                val   = data[p*DATA_W +: DATA_W];
                found = 1'b1;
            end
        end
        return val;
    endfunction

    // Occupancy is tracked exactly, so in_ready never depends on out_ready.
    assign in_ready = (count_q < DEPTH_C);
    assign count    = count_q;

    assign accept = in_valid & in_ready & free_found & rdy & ~flush;
    assign issue  = rdy & ~flush & (~out_valid_q | out_ready) & elig_found;

    // Lowest free slot and lowest eligible slot, both judged on pre-edge state.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        elig_found = 1'b0;
        elig_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!elig_found && busy_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
                elig_found = 1'b1;
                elig_idx   = IDX_W'(i);
            end
        end
    end

    // Entry next state: flush, CDB wakeup, issue clear, then accept into a different slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_d[i]    = busy_q[i];
            op_d[i]      = op_q[i];
            pc_d[i]      = pc_q[i];
            imm_d[i]     = imm_q[i];
            rob_d[i]     = rob_q[i];
            rs1_rdy_d[i] = rs1_rdy_q[i];
            rs1_val_d[i] = rs1_val_q[i];
            rs1_tag_d[i] = rs1_tag_q[i];
            rs2_rdy_d[i] = rs2_rdy_q[i];
            rs2_val_d[i] = rs2_val_q[i];
            rs2_tag_d[i] = rs2_tag_q[i];
        end
        if (rdy && flush) begin
            for (int i = 0; i < DEPTH; i++) busy_d[i] = 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i]) begin
                    if (!rs1_rdy_q[i] && cdb_hit(rs1_tag_q[i], cdb_valid, cdb_tag)) begin
                        rs1_rdy_d[i] = 1'b1;
                        rs1_val_d[i] = cdb_pick(rs1_tag_q[i], cdb_valid, cdb_tag, cdb_data);
                    end
                    if (!rs2_rdy_q[i] && cdb_hit(rs2_tag_q[i], cdb_valid, cdb_tag)) begin
                        rs2_rdy_d[i] = 1'b1;
                        rs2_val_d[i] = cdb_pick(rs2_tag_q[i], cdb_valid, cdb_tag, cdb_data);
                    end
                end
            end
            if (issue) busy_d[elig_idx] = 1'b0;
            if (accept) begin
                busy_d[free_idx]    = 1'b1;
                op_d[free_idx]      = in_op;
                pc_d[free_idx]      = in_pc;
                imm_d[free_idx]     = in_imm;
                rob_d[free_idx]     = in_rob;
                rs1_tag_d[free_idx] = in_rs1_tag;
                rs2_tag_d[free_idx] = in_rs2_tag;
                rs1_rdy_d[free_idx] = in_rs1_rdy | cdb_hit(in_rs1_tag, cdb_valid, cdb_tag);
                rs2_rdy_d[free_idx] = in_rs2_rdy | cdb_hit(in_rs2_tag, cdb_valid, cdb_tag);
                rs1_val_d[free_idx] = in_rs1_rdy ? in_rs1_val
                                                 : cdb_pick(in_rs1_tag, cdb_valid, cdb_tag, cdb_data);
                rs2_val_d[free_idx] = in_rs2_rdy ? in_rs2_val
                                                 : cdb_pick(in_rs2_tag, cdb_valid, cdb_tag, cdb_data);
            end
        end
    end

    // Output register: load on issue, drop valid on drain with nothing eligible, hold otherwise.
    always_comb begin
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_pc_d    = out_pc_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        out_imm_d   = out_imm_q;
        out_rob_d   = out_rob_q;
        if (rdy && flush) begin
            out_valid_d = 1'b0;
        end else if (rdy && (!out_valid_q || out_ready)) begin
            if (elig_found) begin
                out_valid_d = 1'b1;
                out_op_d    = op_q[elig_idx];
                out_pc_d    = pc_q[elig_idx];
                out_rs1_d   = rs1_val_q[elig_idx];
                out_rs2_d   = rs2_val_q[elig_idx];
                out_imm_d   = imm_q[elig_idx];
                out_rob_d   = rob_q[elig_idx];
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Occupancy: accept and issue may cancel in the same cycle; flush empties.
    always_comb begin
        count_d = count_q;
        if (rdy && flush) count_d = '0;
        else              count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
    end

    // Entry control flags carry the reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                busy_q[i]    <= 1'b0;
                rs1_rdy_q[i] <= 1'b0;
                rs2_rdy_q[i] <= 1'b0;
            end else begin
                busy_q[i]    <= busy_d[i];
                rs1_rdy_q[i] <= rs1_rdy_d[i];
                rs2_rdy_q[i] <= rs2_rdy_d[i];
            end
        end
    end

    // Entry payload registers; meaningful only while the entry is busy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            op_q[i]      <= op_d[i];
            pc_q[i]      <= pc_d[i];
            imm_q[i]     <= imm_d[i];
            rob_q[i]     <= rob_d[i];
            rs1_val_q[i] <= rs1_val_d[i];
            rs1_tag_q[i] <= rs1_tag_d[i];
            rs2_val_q[i] <= rs2_val_d[i];
            rs2_tag_q[i] <= rs2_tag_d[i];
        end
    end

    // Output register and occupancy counter, all cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_pc_q    <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_imm_q   <= '0;
            out_rob_q   <= '0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_pc_q    <= out_pc_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
            out_imm_q   <= out_imm_d;
            out_rob_q   <= out_rob_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_pc    = out_pc_q;
    assign out_rs1   = out_rs1_q;
    assign out_rs2   = out_rs2_q;
    assign out_imm   = out_imm_q;
    assign out_rob   = out_rob_q;

endmodule

// File: tb/tb_issue_station.sv
// tb_issue_station: directed scenarios plus randomized traffic for issue_station,
// checked against a rule-level reference model of the station.
module tb_issue_station;
    localparam int DEPTH     = 16;
    localparam int DATA_W    = 32;
    localparam int ROB_W     = 4;
    localparam int OP_W      = 6;
    localparam int IMM_W     = 32;
    localparam int CDB_PORTS = 2;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst, rdy, flush, in_valid, in_ready;
    logic [DATA_W-1:0] in_pc, in_rs1_val, in_rs2_val;
    logic [OP_W-1:0]   in_op;
    logic [ROB_W-1:0]  in_rob, in_rs1_tag, in_rs2_tag;
    logic [IMM_W-1:0]  in_imm;
    logic in_rs1_rdy, in_rs2_rdy;
    logic [CDB_PORTS-1:0]        cdb_valid;
    logic [CDB_PORTS*ROB_W-1:0]  cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0] cdb_data;
    logic out_valid, out_ready;
    logic [OP_W-1:0]   out_op;
    logic [DATA_W-1:0] out_pc, out_rs1, out_rs2;
    logic [IMM_W-1:0]  out_imm;
    logic [ROB_W-1:0]  out_rob;
    logic [CNT_W-1:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    issue_station #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W),
                    .IMM_W(IMM_W), .CDB_PORTS(CDB_PORTS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
        .in_rob(in_rob), .in_imm(in_imm),
        .in_rs1_rdy(in_rs1_rdy), .in_rs1_val(in_rs1_val), .in_rs1_tag(in_rs1_tag),
        .in_rs2_rdy(in_rs2_rdy), .in_rs2_val(in_rs2_val), .in_rs2_tag(in_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_rob(out_rob),
        .count(count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] pc;
        logic [IMM_W-1:0]  imm;
        logic [ROB_W-1:0]  rob;
        logic              r1, r2;
        logic [DATA_W-1:0] v1, v2;
        logic [ROB_W-1:0]  t1, t2;
    } ent_t;

    ent_t              m_e [DEPTH];
    logic              m_ov;
    logic [OP_W-1:0]   m_op;
    logic [DATA_W-1:0] m_pc, m_rs1, m_rs2;
    logic [IMM_W-1:0]  m_imm;
    logic [ROB_W-1:0]  m_rob;

    function automatic int model_count();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_e[i].busy) n++;
        return n;
    endfunction

    // Scan ports high to low so the lowest-numbered matching port is the last to write.
    function automatic bit cdb_find(input logic [ROB_W-1:0] tag, output logic [DATA_W-1:0] val);
        bit hit;
        hit = 1'b0;
        val = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_tag[p*ROB_W +: ROB_W] == tag) begin
                hit = 1'b1;
                val = cdb_data[p*DATA_W +: DATA_W];
            end
        end
        return hit;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then
    // let the DUT take the same edge; returns 1 time unit after the edge.
    task automatic step();
        ent_t nx [DEPTH];
        ent_t ne;
        int e, f;
        logic [DATA_W-1:0] v;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_e[i].busy = 1'b0; m_e[i].r1 = 1'b0; m_e[i].r2 = 1'b0;
            end
            m_ov = 1'b0; m_op = '0; m_pc = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_rob = '0;
        end else if (rdy && flush) begin
            for (int i = 0; i < DEPTH; i++) m_e[i].busy = 1'b0;
            m_ov = 1'b0;
        end else if (rdy) begin
            nx = m_e;
            e = -1;
            f = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (e < 0 && m_e[i].busy && m_e[i].r1 && m_e[i].r2) e = i;
                if (f < 0 && !m_e[i].busy) f = i;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (m_e[i].busy && !m_e[i].r1 && cdb_find(m_e[i].t1, v)) begin nx[i].r1 = 1'b1; nx[i].v1 = v; end
                if (m_e[i].busy && !m_e[i].r2 && cdb_find(m_e[i].t2, v)) begin nx[i].r2 = 1'b1; nx[i].v2 = v; end
            end
            if (!m_ov || out_ready) begin
                if (e >= 0) begin
                    m_ov = 1'b1; m_op = m_e[e].op; m_pc = m_e[e].pc; m_rs1 = m_e[e].v1;
                    m_rs2 = m_e[e].v2; m_imm = m_e[e].imm; m_rob = m_e[e].rob;
                    nx[e].busy = 1'b0;
                end else begin
                    m_ov = 1'b0;
                end
            end
            if (in_valid && model_count() < DEPTH) begin
                ne.busy = 1'b1; ne.op = in_op; ne.pc = in_pc; ne.imm = in_imm; ne.rob = in_rob;
                ne.r1 = in_rs1_rdy; ne.v1 = in_rs1_val; ne.t1 = in_rs1_tag;
                ne.r2 = in_rs2_rdy; ne.v2 = in_rs2_val; ne.t2 = in_rs2_tag;
                if (!in_rs1_rdy && cdb_find(in_rs1_tag, v)) begin ne.r1 = 1'b1; ne.v1 = v; end
                if (!in_rs2_rdy && cdb_find(in_rs2_tag, v)) begin ne.r2 = 1'b1; ne.v2 = v; end
                nx[f] = ne;
            end
            m_e = nx;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_op = '0; in_rob = '0; in_imm = '0;
        in_rs1_rdy = 1'b0; in_rs1_val = '0; in_rs1_tag = '0;
        in_rs2_rdy = 1'b0; in_rs2_val = '0; in_rs2_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic offer(input logic [ROB_W-1:0] rob, input logic r1, input logic [ROB_W-1:0] t1,
                         input logic r2, input logic [ROB_W-1:0] t2);
        in_valid = 1'b1; in_rob = rob;
        in_pc = $urandom; in_op = OP_W'($urandom); in_imm = $urandom;
        in_rs1_rdy = r1; in_rs1_tag = t1; in_rs1_val = $urandom;
        in_rs2_rdy = r2; in_rs2_tag = t2; in_rs2_val = $urandom;
    endtask

    task automatic rand_inputs(input bit allow_stall);
        rdy        = allow_stall ? ($urandom_range(0, 9) != 0) : 1'b1;
        flush      = ($urandom_range(0, 39) == 0);
        in_valid   = ($urandom_range(0, 2) != 0);
        out_ready  = ($urandom_range(0, 3) != 0);
        in_op      = OP_W'($urandom);
        in_pc      = $urandom;
        in_rob     = ROB_W'($urandom);
        in_imm     = $urandom;
        in_rs1_rdy = ($urandom_range(0, 1) != 0);
        in_rs1_val = $urandom;
        in_rs1_tag = ROB_W'($urandom_range(0, 3));
        in_rs2_rdy = ($urandom_range(0, 1) != 0);
        in_rs2_val = $urandom;
        in_rs2_tag = ROB_W'($urandom_range(0, 3));
        for (int p = 0; p < CDB_PORTS; p++) begin
            cdb_valid[p]                 = ($urandom_range(0, 2) == 0);
            cdb_tag[p*ROB_W +: ROB_W]    = ROB_W'($urandom_range(0, 3));
            cdb_data[p*DATA_W +: DATA_W] = $urandom;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; rdy = 1'b0; flush = 1'b1; in_valid = 1'b1;
        step();
        step();
        idle_inputs();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({out_op, out_pc, out_rs1, out_rs2, out_imm, out_rob} !== '0) begin
            n_bad++; $display("FAIL reset_out_fields: got %h want 0", {out_op, out_pc, out_rs1, out_rs2, out_imm, out_rob});
        end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] rs1s [DEPTH];
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            offer(ROB_W'(i), 1'b1, '0, 1'b1, '0);
            rs1s[i] = in_rs1_val;
            step();
            n_cmp++; if (count !== CNT_W'(1)) begin n_bad++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count); end
            if (i == 0) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_first_latency: got %b want 0", out_valid); end
            end else begin
                n_cmp++; if (out_valid !== 1'b1 || out_rob !== ROB_W'(i - 1) || out_rs1 !== rs1s[i-1]) begin
                    n_bad++; $display("FAIL stream_issue[%0d]: got v=%b rob=%0d rs1=%h want v=1 rob=%0d rs1=%h",
                                      i, out_valid, out_rob, out_rs1, i - 1, rs1s[i-1]);
                end
            end
        end
        idle_inputs();
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_rob !== ROB_W'(DEPTH - 1) || count !== '0) begin
            n_bad++; $display("FAIL stream_last: got v=%b rob=%0d cnt=%0d want v=1 rob=%0d cnt=0", out_valid, out_rob, count, DEPTH - 1);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_fill_wakeup();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            offer(ROB_W'(i), 1'b0, ROB_W'(5), 1'b1, '0);
            step();
        end
        n_cmp++; if (count !== CNT_W'(DEPTH) || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL full_state: got cnt=%0d rdy=%b v=%b want cnt=%0d rdy=0 v=0", count, in_ready, out_valid, DEPTH);
        end
        offer(ROB_W'(9), 1'b1, '0, 1'b1, '0);
        step();
        n_cmp++; if (count !== CNT_W'(DEPTH) || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_reject: got cnt=%0d rdy=%b want cnt=%0d rdy=0", count, in_ready, DEPTH);
        end
        idle_inputs();
        cdb_valid = 2'b10;
        cdb_tag   = {4'd5, 4'd0};
        cdb_data  = {32'hDEADBEEF, 32'h0};
        step();
        idle_inputs();
        n_cmp++; if (out_valid !== 1'b0 || count !== CNT_W'(DEPTH)) begin
            n_bad++; $display("FAIL wake_edge: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, count, DEPTH);
        end
        for (int k = 0; k < DEPTH; k++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_rob !== ROB_W'(k) || out_rs1 !== 32'hDEADBEEF || count !== CNT_W'(DEPTH - 1 - k)) begin
                n_bad++; $display("FAIL wake_issue[%0d]: got v=%b rob=%0d rs1=%h cnt=%0d want v=1 rob=%0d rs1=deadbeef cnt=%0d",
                                  k, out_valid, out_rob, out_rs1, count, k, DEPTH - 1 - k);
            end
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL wake_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_forward();
        idle_inputs();
        offer(ROB_W'(7), 1'b1, '0, 1'b0, ROB_W'(3));
        cdb_valid = 2'b11;
        cdb_tag   = {4'd3, 4'd3};
        cdb_data  = {32'h9999, 32'h1234};
        step();
        idle_inputs();
        n_cmp++; if (out_valid !== 1'b0 || count !== CNT_W'(1)) begin
            n_bad++; $display("FAIL fwd_accept: got v=%b cnt=%0d want v=0 cnt=1", out_valid, count);
        end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_rs2 !== 32'h1234 || out_rob !== ROB_W'(7) || count !== '0) begin
            n_bad++; $display("FAIL fwd_issue: got v=%b rs2=%h rob=%0d cnt=%0d want v=1 rs2=1234 rob=7 cnt=0", out_valid, out_rs2, out_rob, count);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] held_pc;
        logic [ROB_W-1:0]  exp_rob [3];
        idle_inputs();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            offer(ROB_W'(i), 1'b1, '0, 1'b1, '0);
            out_ready = 1'b0;
            step();
        end
        idle_inputs();
        out_ready = 1'b0;
        held_pc = m_pc;
        n_cmp++; if (count !== CNT_W'(3) || out_valid !== 1'b1 || out_rob !== ROB_W'(1)) begin
            n_bad++; $display("FAIL bp_setup: got cnt=%0d v=%b rob=%0d want cnt=3 v=1 rob=1", count, out_valid, out_rob);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_rob !== ROB_W'(1) || out_pc !== held_pc || count !== CNT_W'(3)) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v=%b rob=%0d pc=%h cnt=%0d want v=1 rob=1 pc=%h cnt=3",
                                  k, out_valid, out_rob, out_pc, count, held_pc);
            end
        end
        // slots hold rob3 (slot0), rob2 (slot1), rob4 (slot2)
        exp_rob[0] = 4'd3; exp_rob[1] = 4'd2; exp_rob[2] = 4'd4;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_rob !== exp_rob[k] || count !== CNT_W'(2 - k)) begin
                n_bad++; $display("FAIL bp_release[%0d]: got v=%b rob=%0d cnt=%0d want v=1 rob=%0d cnt=%0d",
                                  k, out_valid, out_rob, count, exp_rob[k], 2 - k);
            end
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) offer(ROB_W'(8 + i), 1'b1, '0, 1'b1, '0);
            else       offer(ROB_W'(8 + i), 1'b0, ROB_W'(6), 1'b1, '0);
            out_ready = 1'b0;
            step();
        end
        n_cmp++; if (count !== CNT_W'(7) || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL flush_setup: got cnt=%0d v=%b want cnt=7 v=1", count, out_valid);
        end
        offer(ROB_W'(0), 1'b1, '0, 1'b1, '0);
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush_clear: got cnt=%0d v=%b rdy=%b want cnt=0 v=0 rdy=1", count, out_valid, in_ready);
        end
        cdb_valid = 2'b01;
        cdb_tag   = {4'd0, 4'd6};
        cdb_data  = {32'h0, 32'hCAFE0006};
        step();
        idle_inputs();
        step();
        n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_stale_cdb: got cnt=%0d v=%b want cnt=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_stall();
        logic [CNT_W-1:0] snap_cnt;
        logic             snap_ov;
        logic [DATA_W-1:0] snap_pc;
        logic [ROB_W-1:0]  snap_rob;
        for (int c = 0; c < 12; c++) begin
            rand_inputs(1'b0);
            flush = 1'b0;
            step();
        end
        snap_cnt = CNT_W'(model_count()); snap_ov = m_ov; snap_pc = m_pc; snap_rob = m_rob;
        for (int c = 0; c < 3; c++) begin
            rand_inputs(1'b0);
            rdy = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = (c == 1);
            cdb_valid = 2'b11;
            step();
            n_cmp++; if (count !== snap_cnt || out_valid !== snap_ov || out_pc !== snap_pc || out_rob !== snap_rob) begin
                n_bad++; $display("FAIL stall_frozen[%0d]: got cnt=%0d v=%b pc=%h rob=%0d want cnt=%0d v=%b pc=%h rob=%0d",
                                  c, count, out_valid, out_pc, out_rob, snap_cnt, snap_ov, snap_pc, snap_rob);
            end
        end
        for (int c = 0; c < 20; c++) begin
            rand_inputs(1'b0);
            step();
            n_cmp++; if (out_valid !== m_ov || count !== CNT_W'(model_count()) || in_ready !== (model_count() < DEPTH)) begin
                n_bad++; $display("FAIL stall_resume_ctrl[%0d]: got v=%b cnt=%0d rdy=%b want v=%b cnt=%0d rdy=%b",
                                  c, out_valid, count, in_ready, m_ov, model_count(), model_count() < DEPTH);
            end
            n_cmp++; if ({out_op, out_pc, out_rs1, out_rs2, out_imm, out_rob} !== {m_op, m_pc, m_rs1, m_rs2, m_imm, m_rob}) begin
                n_bad++; $display("FAIL stall_resume_data[%0d]: got %h want %h", c,
                                  {out_op, out_pc, out_rs1, out_rs2, out_imm, out_rob}, {m_op, m_pc, m_rs1, m_rs2, m_imm, m_rob});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rand_inputs(1'b1);
            step();
            n_cmp++; if (out_valid !== m_ov || count !== CNT_W'(model_count()) || in_ready !== (model_count() < DEPTH)) begin
                n_bad++; $display("FAIL rand_ctrl[%0d]: got v=%b cnt=%0d rdy=%b want v=%b cnt=%0d rdy=%b",
                                  c, out_valid, count, in_ready, m_ov, model_count(), model_count() < DEPTH);
            end
            n_cmp++; if ({out_op, out_pc, out_rs1, out_rs2, out_imm, out_rob} !== {m_op, m_pc, m_rs1, m_rs2, m_imm, m_rob}) begin
                n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", c,
                                  {out_op, out_pc, out_rs1, out_rs2, out_imm, out_rob}, {m_op, m_pc, m_rs1, m_rs2, m_imm, m_rob});
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_wakeup();
        test_forward();
        test_backpressure();
        test_flush();
        test_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_station.md
# issue_station

Parametrised reservation station between the decoder/register file and one execution unit. It buffers up to DEPTH decoded instructions and captures missing operands from CDB_PORTS common-data-bus broadcasts. It issues one operand-complete instruction per cycle, lowest index first, through a valid/ready output register. It supports pipeline flush and a global stall, and it keeps an exact occupancy count so `in_ready` never over-reports space.

## Interface
- DEPTH, 16: number of entries, at least 2.
- DATA_W, 32: operand and PC width.
- ROB_W, 4: ROB tag width.
- OP_W, 6: op-id width.
- IMM_W, 32: immediate width.
- CDB_PORTS, 2: number of broadcast buses, at least 1.
- CNT_W, $clog2(DEPTH+1): width of `count`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when 0, all state holds.
- flush  in  1  mispredict flush.
- in_valid  in  1  decoder offers an instruction.
- in_ready  out  1  at least one free entry (`count < DEPTH`).
- in_pc  in  DATA_W  instruction PC.
- in_op  in  OP_W  op id.
- in_rob  in  ROB_W  destination ROB tag.
- in_imm  in  IMM_W  immediate.
- in_rs1_rdy  in  1  rs1 value is available now.
- in_rs1_val  in  DATA_W  rs1 value.
- in_rs1_tag  in  ROB_W  rs1 producer tag.
- in_rs2_rdy  in  1  rs2 value is available now.
- in_rs2_val  in  DATA_W  rs2 value.
- in_rs2_tag  in  ROB_W  rs2 producer tag.
- cdb_valid  in  CDB_PORTS  one valid bit per broadcast port.
- cdb_tag  in  CDB_PORTS*ROB_W  packed tags; port p occupies bits [p*ROB_W +: ROB_W].
- cdb_data  in  CDB_PORTS*DATA_W  packed results, same packing.
- out_valid  out  1  issue register holds an instruction.
- out_ready  in  1  execution unit accepts the instruction.
- out_op, out_pc, out_rs1, out_rs2, out_imm, out_rob  out  as in the input fields  issued instruction.
- count  out  CNT_W  number of occupied entries.

## Operation
- Per-entry state: busy, op, pc, imm, rob, and for each of rs1/rs2 a value, a tag and a rdy bit.
- An entry is eligible when busy and both rdy bits are set.
- Accept:
  - Occurs when `in_valid & in_ready & rdy & ~flush`.
  - The instruction is written to the lowest-index non-busy entry, judged on pre-edge state.
- Insert-time forwarding:
  - If an operand's rdy input is 0 and a valid CDB port carries its tag this cycle, the entry stores cdb_data with rdy set.
- Wakeup:
  - Every busy entry with an operand waiting on a valid CDB tag captures the data and sets rdy.
  - If several ports match, the lowest-numbered port wins.
- Issue:
  - Occurs when `rdy & ~flush & (~out_valid | out_ready)` and at least one entry is eligible.
  - The lowest-index eligible entry is copied into the output register and cleared; out_valid goes to 1.
  - If the output register drains (`out_ready`) and no entry is eligible, out_valid goes to 0.
  - While `out_valid & ~out_ready`, all out_* hold stable.
- Accept and issue in the same cycle use different slots. A slot freed by issue is not reusable until the next cycle.
- count = previous count + accept − issue; range 0..DEPTH; no wrap.
- flush (with rdy high) clears all busy bits and out_valid; count → 0; accept and wakeup that cycle are discarded.
- rdy = 0: no accept, no issue, no wakeup, no flush; out_* hold.

## Timing
- Reset values:
  - All busy and rdy bits 0.
  - out_valid 0, all out_* fields 0.
  - count 0, in_ready 1.
- Accept at edge N, operands ready → out_valid at edge N+1 at the earliest.
- An entry woken by CDB at edge N is eligible at edge N+1.
- An operand forwarded at insert follows the same timing as one that arrived ready.
- in_ready and count are registered-state derived (combinational from flops). No combinational path from out_ready to in_ready.
- flush is asserted together with a full station: in_ready returns to 1 at the next cycle.
- rst overrides flush and rdy.

## Test plan
- Reset, then 16 accepts with both operands ready and out_ready=1 → one issue per cycle from N+1; out_rob matches input order; count peaks at 1.
- 16 accepts with in_rs1_rdy=0 and tag 5 → in_ready=0 with count=16; a 17th in_valid is not accepted. Then cdb port 1 tag 5, data 0xDEADBEEF → all 16 entries issue over 16 cycles with out_rs1=0xDEADBEEF.
- Accept with rs2 tag 3 while cdb port 0 carries tag 3, data 0x1234, in the same cycle → issues at N+1 with out_rs2=0x1234.
- out_ready=0 for 4 cycles with 3 ready entries → out_* stable and out_valid=1 for the 4 cycles; then one issue per cycle, lowest index first.
- Station at count=7, out_valid=1, flush → next cycle count=0, out_valid=0, in_ready=1; a later CDB with a stale tag has no effect.
- rdy=0 for 3 cycles during accept, wakeup and issue traffic → all outputs and count frozen; operation resumes as if the cycles never occurred.
